// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state and owner encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_LDR
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way core/loader picker; MEM_ARB_RR_EN selects round-robin, else core priority
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   core_req,
    input  logic   ldr_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = core_req | ldr_req;
        grant_owner = OWN_CORE;
`ifdef MEM_ARB_RR_EN
        // On a tie the side that did not win last time goes next.
        if (core_req && ldr_req) begin
            grant_owner = (last_owner == OWN_CORE) ? OWN_LDR : OWN_CORE;
        end else if (ldr_req) begin
            grant_owner = OWN_LDR;
        end
`else
        if (!core_req && ldr_req) begin
            grant_owner = OWN_LDR;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between core M stage and loader; MEM_ARB_RR_EN enables round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_re,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              stall_m,
    output logic              valid_mem,
    output logic [DATA_W-1:0] rdata_w,
    input  logic              ldr_valid,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ready,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_req_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              core_req;
    logic              grant_valid;
    owner_t            grant_owner;
    logic              core_done;

    assign core_req = core_re | core_we;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_LDR;
        end else if (state == IDLE && grant_valid) begin
            last_owner <= grant_owner;
        end
    end

    mem_arb_pick u_pick (
        .core_req    (core_req),
        .ldr_req     (ldr_valid),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`else
    mem_arb_pick u_pick (
        .core_req    (core_req),
        .ldr_req     (ldr_valid),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The grant is latched once in IDLE so the memory request stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= OWN_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid_mem <= 1'b0;
            rdata_w   <= '0;
            ldr_rdata <= '0;
        end else begin
            valid_mem <= core_done && !we_q;
            if (state == IDLE && grant_valid) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_CORE) begin
                    we_q    <= core_we;
                    addr_q  <= core_addr;
                    wdata_q <= core_wdata;
                end else begin
                    we_q    <= ldr_we;
                    addr_q  <= ldr_addr;
                    wdata_q <= ldr_wdata;
                end
            end
            if (state == WAIT_R && mem_rvalid) begin
                if (owner_q == OWN_CORE) begin
                    rdata_w <= mem_rdata;
                end else begin
                    ldr_rdata <= mem_rdata;
                end
            end
        end
    end

    assign core_done  = (state == DONE) && (owner_q == OWN_CORE);
    assign stall_m    = core_req && !core_done;
    assign ldr_ready  = (state == DONE) && (owner_q == OWN_LDR);
    assign ldr_rvalid = ldr_ready && !we_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_re, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        stall_m, valid_mem;
    logic [31:0] rdata_w;
    logic        ldr_valid, ldr_we;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_ready, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        mem_req_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_req_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_re       (core_re),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .stall_m       (stall_m),
        .valid_mem     (valid_mem),
        .rdata_w       (rdata_w),
        .ldr_valid     (ldr_valid),
        .ldr_we        (ldr_we),
        .ldr_addr      (ldr_addr),
        .ldr_wdata     (ldr_wdata),
        .ldr_ready     (ldr_ready),
        .ldr_rvalid    (ldr_rvalid),
        .ldr_rdata     (ldr_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_req_ready (mem_req_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic        c_re, c_we;
        logic [31:0] c_addr, c_wdata;
        logic        l_val, l_we;
        logic [31:0] l_addr;
        logic        m_rdy, m_rv;
        logic [31:0] m_rdata;
        logic        e_stall, e_rv, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_vm;
        logic [31:0] e_rdw;
        logic        e_lr, e_lrv;
        logic [31:0] e_lrd;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic c_re, input logic c_we, input logic [31:0] c_addr, input logic [31:0] c_wdata,
        input logic l_val, input logic l_we, input logic [31:0] l_addr,
        input logic m_rdy, input logic m_rv, input logic [31:0] m_rdata,
        input logic e_stall, input logic e_rv, input logic e_we, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic e_vm, input logic [31:0] e_rdw,
        input logic e_lr, input logic e_lrv, input logic [31:0] e_lrd);
        vec_t v;
        v.c_re = c_re; v.c_we = c_we; v.c_addr = c_addr; v.c_wdata = c_wdata;
        v.l_val = l_val; v.l_we = l_we; v.l_addr = l_addr;
        v.m_rdy = m_rdy; v.m_rv = m_rv; v.m_rdata = m_rdata;
        v.e_stall = e_stall; v.e_rv = e_rv; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_vm = e_vm; v.e_rdw = e_rdw;
        v.e_lr = e_lr; v.e_lrv = e_lrv; v.e_lrd = e_lrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        core_re = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        ldr_valid = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] R = 32'h12345678;
    localparam logic [31:0] C = 32'hCAFEF00D;

    logic got_we[4];
    int   n;
    int   cyc;
    logic found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        idle_inputs();

        // Reset state, core write, core read with delayed ready/rvalid, loader read, stray rvalid in IDLE.
        vecs[0]  = mk(0,0,0,0,        0,0,0, 0,0,0,            0,0,0,0,0,         0,0, 0,0,0);
        vecs[1]  = mk(0,1,32'h100,D,  0,0,0, 0,0,0,            1,0,0,0,0,         0,0, 0,0,0);
        vecs[2]  = mk(0,1,32'h100,D,  0,0,0, 1,0,0,            1,1,1,32'h100,D,   0,0, 0,0,0);
        vecs[3]  = mk(0,1,32'h100,D,  0,0,0, 0,0,0,            0,0,0,0,0,         0,0, 0,0,0);
        vecs[4]  = mk(1,0,32'h200,0,  0,0,0, 0,0,0,            1,0,0,0,0,         0,0, 0,0,0);
        vecs[5]  = mk(1,0,32'h200,0,  0,0,0, 0,0,0,            1,1,0,32'h200,0,   0,0, 0,0,0);
        vecs[6]  = mk(1,0,32'h200,0,  0,0,0, 0,0,0,            1,1,0,32'h200,0,   0,0, 0,0,0);
        vecs[7]  = mk(1,0,32'h200,0,  0,0,0, 1,0,0,            1,1,0,32'h200,0,   0,0, 0,0,0);
        vecs[8]  = mk(1,0,32'h200,0,  0,0,0, 0,0,0,            1,0,0,0,0,         0,0, 0,0,0);
        vecs[9]  = mk(1,0,32'h200,0,  0,0,0, 0,1,R,            1,0,0,0,0,         0,0, 0,0,0);
        vecs[10] = mk(1,0,32'h200,0,  0,0,0, 0,0,0,            0,0,0,0,0,         0,R, 0,0,0);
        vecs[11] = mk(0,0,0,0,        0,0,0, 0,0,0,            0,0,0,0,0,         1,R, 0,0,0);
        vecs[12] = mk(0,0,0,0,        0,0,0, 0,1,32'hFFFF0000, 0,0,0,0,0,         0,R, 0,0,0);
        vecs[13] = mk(0,0,0,0,        1,0,4, 0,0,0,            0,0,0,0,0,         0,R, 0,0,0);
        vecs[14] = mk(0,0,0,0,        1,0,4, 1,0,0,            0,1,0,4,0,         0,R, 0,0,0);
        vecs[15] = mk(0,0,0,0,        1,0,4, 0,1,C,            0,0,0,0,0,         0,R, 0,0,0);
        vecs[16] = mk(0,0,0,0,        1,0,4, 0,0,0,            0,0,0,0,0,         0,R, 1,1,C);
        vecs[17] = mk(0,0,0,0,        0,0,0, 0,0,0,            0,0,0,0,0,         0,R, 0,0,C);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            core_re = vecs[i].c_re; core_we = vecs[i].c_we;
            core_addr = vecs[i].c_addr; core_wdata = vecs[i].c_wdata;
            ldr_valid = vecs[i].l_val; ldr_we = vecs[i].l_we;
            ldr_addr = vecs[i].l_addr; ldr_wdata = 0;
            mem_req_ready = vecs[i].m_rdy; mem_rvalid = vecs[i].m_rv; mem_rdata = vecs[i].m_rdata;
            #1;
            chk($sformatf("row%0d stall_m", i), {31'b0, stall_m}, {31'b0, vecs[i].e_stall});
            chk($sformatf("row%0d mem_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv) begin
                chk($sformatf("row%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
                chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            chk($sformatf("row%0d valid_mem", i), {31'b0, valid_mem}, {31'b0, vecs[i].e_vm});
            chk($sformatf("row%0d rdata_w", i), rdata_w, vecs[i].e_rdw);
            chk($sformatf("row%0d ldr_ready", i), {31'b0, ldr_ready}, {31'b0, vecs[i].e_lr});
            chk($sformatf("row%0d ldr_rvalid", i), {31'b0, ldr_rvalid}, {31'b0, vecs[i].e_lrv});
            chk($sformatf("row%0d ldr_rdata", i), ldr_rdata, vecs[i].e_lrd);
        end

        // Core reads and loader writes requesting continuously; record the first four grants.
        do_reset();
        core_re = 1; core_addr = 32'h300;
        ldr_valid = 1; ldr_we = 1; ldr_addr = 32'h8; ldr_wdata = 32'hA5;
        mem_req_ready = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        for (int k = 0; k < 4; k++) got_we[k] = 1'bx;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            #1;
            if (mem_req_valid) begin
                got_we[n] = mem_we;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("arb grant count", n, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            chk($sformatf("arb grant%0d is_loader", k), {31'b0, got_we[k]}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
            chk($sformatf("arb grant%0d is_loader", k), {31'b0, got_we[k]}, 32'd0);
`endif
        end
        idle_inputs();

        // Reset while waiting for read data, then a stray response, then a clean core read.
        do_reset();
        core_re = 1; core_addr = 32'h40; mem_req_ready = 1; mem_rvalid = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort in WAIT_R stall_m", {31'b0, stall_m}, 32'd1);
        chk("abort in WAIT_R mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        reset = 1;
        @(negedge clk);
        reset = 0; core_re = 0; mem_rvalid = 1; mem_rdata = 32'h00000BAD;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stray%0d valid_mem", k), {31'b0, valid_mem}, 32'd0);
            chk($sformatf("stray%0d ldr_rvalid", k), {31'b0, ldr_rvalid}, 32'd0);
            chk($sformatf("stray%0d mem_req_valid", k), {31'b0, mem_req_valid}, 32'd0);
            chk($sformatf("stray%0d rdata_w", k), rdata_w, 32'd0);
            @(negedge clk);
        end
        core_re = 1; core_addr = 32'h44; mem_rdata = 32'h55AA55AA;
        found = 0;
        cyc = 0;
        while (!found && cyc < 12) begin
            #1;
            if (valid_mem) begin
                found = 1;
            end else begin
                if (!stall_m) core_re = 0;
                @(negedge clk);
                cyc++;
            end
        end
        chk("post-reset read valid_mem seen", {31'b0, found}, 32'd1);
        chk("post-reset read rdata_w", rdata_w, 32'h55AA55AA);
        chk("post-reset read latency", cyc, 4);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, memory address width.
REQ-002 Parameter: DATA_W, 32, memory data width.
REQ-003 Single clock clk; reset is synchronous and active-high.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 core_re / core_we  in  1 each  core M-stage load/store request; never both high.
REQ-007 core_addr / core_wdata  in  ADDR_W / DATA_W  core request address and write data.
REQ-008 stall_m  out  1  hold core M stage.
REQ-009 valid_mem / rdata_w  out  1 / DATA_W  core read data to W stage.
REQ-010 ldr_valid / ldr_we  in  1 each  loader request and write flag.
REQ-011 ldr_addr / ldr_wdata  in  ADDR_W / DATA_W  loader address and write data.
REQ-012 ldr_ready / ldr_rvalid / ldr_rdata  out  1 / 1 / DATA_W  loader completion, read-valid and read data.
REQ-013 mem_req_valid / mem_we  out  1 each  memory request and write flag.
REQ-014 mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory request address and write data.
REQ-015 mem_req_ready  in  1  memory accepts the request.
REQ-016 mem_rvalid / mem_rdata  in  1 / DATA_W  memory read response.

Function
REQ-017 FSM states: IDLE, REQ, WAIT_R, DONE; one transaction outstanding at a time.
REQ-018 IDLE: if any request is pending, register the grant (owner, we, addr, wdata) and go to REQ; otherwise stay in IDLE.
REQ-019 REQ: mem_req_valid=1, driven from the registered grant. On mem_req_ready go to WAIT_R for reads, or DONE for writes.
REQ-020 WAIT_R: on mem_rvalid, capture mem_rdata and go to DONE. mem_rvalid is sampled only in WAIT_R; a response arriving in the acceptance cycle itself is not supported.
REQ-021 DONE: lasts one cycle, then IDLE. A new grant can be made in the following IDLE cycle.
REQ-022 stall_m = (core_re|core_we) & ~(state==DONE & owner==core), combinational.
REQ-023 The cycle after a core DONE, the core inputs carry a new request.
REQ-024 Core read: valid_mem is a registered one-cycle pulse in the cycle after DONE, with rdata_w = captured data.
REQ-025 Core write: valid_mem is not asserted.
REQ-026 Loader: ldr_ready=1 in DONE. For reads, ldr_rvalid=1 and ldr_rdata=captured data in the same cycle.
REQ-027 Loader inputs hold stable until ldr_ready.
REQ-028 Minimum latency with ready and rvalid both immediate:
  - core write: stall_m drops 2 cycles after the request appears;
  - core read: stall_m drops after 3 cycles; valid_mem follows after 4 cycles.
REQ-029 mem_addr, mem_wdata and mem_we hold constant while mem_req_valid=1 and mem_req_ready=0.
REQ-030 Requests arriving while the FSM is busy wait in IDLE arbitration; none is dropped.

Reset
REQ-031 Reset forces IDLE, clears the grant, and sets mem_req_valid, valid_mem, ldr_ready and ldr_rvalid to 0.
REQ-032 After reset, last-owner = loader, so the first tie under round-robin goes to the core. rdata_w and ldr_rdata reset to 0.
REQ-033 Reset mid-transaction abandons it with no completion pulse. A later mem_rvalid is ignored while not in WAIT_R.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: round-robin on a simultaneous core and loader request; the requester not granted last wins.
REQ-035 Macro MEM_ARB_RR_EN undefined: fixed priority, core always wins, and no last-owner register is built.

Structure
REQ-036 Package mem_arb_pkg: state enum {IDLE, REQ, WAIT_R, DONE} and owner enum {OWN_CORE, OWN_LDR}.
REQ-037 Sub-module mem_arb_pick: combinational two-way picker (requests, last owner -> grant), holding the MEM_ARB_RR_EN selection.

Verification
REQ-038 Core write: core_we=1, addr 0x100, data 0xDEADBEEF, ready immediate -> mem_we=1 with that addr/data in cycle 1; stall_m low in cycle 2; no valid_mem.
REQ-039 Core read: core_re=1, addr 0x200, ready after 3 cycles, rvalid 2 cycles after acceptance with 0x12345678 -> stall_m held until DONE; valid_mem=1 with rdata_w=0x12345678 exactly one cycle after DONE.
REQ-040 Simultaneous core read and loader write, repeated 4 times:
  - with MEM_ARB_RR_EN: grants alternate core, loader, core, loader;
  - without MEM_ARB_RR_EN: core served first every time.
REQ-041 Loader read: addr 0x4, mem_rdata 0xCAFEF00D -> ldr_ready=ldr_rvalid=1 for one cycle with ldr_rdata=0xCAFEF00D; stall_m stays 0.
REQ-042 Reset asserted in WAIT_R, then a stray mem_rvalid -> FSM in IDLE and no valid_mem/ldr_rvalid pulse. A subsequent core request completes normally.
